// File: rtl/calc_core_param_if.sv
// Keypad-side inputs and display-side outputs of the calculator core.
interface calc_core_param_if #(
    parameter int WIDTH = 16
);
    logic             key_pressed;
    logic [3:0]       key_code;
    logic [WIDTH-1:0] disp_mag;
    logic             disp_neg;
    logic             err;
    logic             busy;
    logic [3:0]       state_dbg;
    logic [7:0]       key_count;

    // Handshake: no valid/ready pair. A key is the rising edge of key_pressed with key_code
    // stable while high; the core takes it only while busy=0, and keys seen while busy=1 are lost.
    modport master (
        output key_pressed, key_code,
        input  disp_mag, disp_neg, err, busy, state_dbg, key_count
    );

    modport slave (
        input  key_pressed, key_code,
        output disp_mag, disp_neg, err, busy, state_dbg, key_count
    );
endinterface

// File: rtl/calc_core_param.sv
// Keypad-driven signed chained calculator: decimal operand entry, add/sub/mul, a restoring
// shift-subtract divider, sign-plus-magnitude display and a latched error flag.
module calc_core_param #(
    parameter int WIDTH   = 16,
    parameter int MAX_ARG = 9999
) (
    input  logic             Clk,
    input  logic             reset,
    calc_core_param_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH+3:0] MAX_ARG_W = MAX_ARG;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DIGIT    = 4'd1,
        S_SHOW_ARG = 4'd5,
        S_CALC     = 4'd6,
        S_SHOW_RES = 4'd7,
        S_CLEAR    = 4'd8,
        S_DIV      = 4'd9,
        S_ERROR    = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        OP_PLUS  = 3'd0,
        OP_MINUS = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_LOAD  = 3'd4
    } op_t;

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    op_t                     op_next_q, op_next_d;
    logic [WIDTH-1:0]        arg_q, arg_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] disp_q, disp_d;
    logic                    entered_q, entered_d;
    logic                    prev_key_q;
    logic [3:0]              key_q, key_d;
    logic                    err_q, err_d;
    logic [7:0]              count_q, count_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [WIDTH-1:0]        dvs_q, dvs_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    qneg_q, qneg_d;

    logic key_event;
    assign key_event = bus.key_pressed & ~prev_key_q;

    // Digit append, kept wide enough that arg*10+9 never wraps before the limit test.
    logic [WIDTH+3:0] arg_wide;
    logic [WIDTH+3:0] arg_append;
    logic             arg_fits;
    assign arg_wide   = {4'b0000, arg_q};
    assign arg_append = (arg_wide << 3) + (arg_wide << 1) + {{WIDTH{1'b0}}, key_q};
    assign arg_fits   = (arg_append <= MAX_ARG_W);

    logic signed [W2-1:0] acc_w;
    logic signed [W2-1:0] arg_w;
    logic signed [W2-1:0] calc_res;
    logic                 calc_fits;
    assign acc_w = {{WIDTH{acc_q[WIDTH-1]}}, acc_q};
    assign arg_w = {{WIDTH{1'b0}}, arg_q};

    always_comb begin
        calc_res = acc_w;
        case (op_q)
            OP_PLUS:  calc_res = acc_w + arg_w;
            OP_MINUS: calc_res = acc_w - arg_w;
            OP_MUL:   calc_res = acc_w * arg_w;
            OP_LOAD:  calc_res = entered_q ? arg_w : acc_w;
            default:  calc_res = acc_w;
        endcase
    end

    // The exact result fits in WIDTH signed bits iff its top WIDTH+1 bits are all sign copies.
    assign calc_fits = (&calc_res[W2-1:WIDTH-1]) | ~(|calc_res[W2-1:WIDTH-1]);

    logic [WIDTH:0]          rem_sh;
    logic [WIDTH:0]          rem_sub;
    logic                    quo_bit;
    logic [WIDTH-1:0]        quo_step;
    logic signed [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0]        acc_abs;
    assign rem_sh     = {rem_q, quo_q[WIDTH-1]};
    assign rem_sub    = rem_sh - {1'b0, dvs_q};
    assign quo_bit    = ~rem_sub[WIDTH];
    assign quo_step   = {quo_q[WIDTH-2:0], quo_bit};
    assign quo_signed = quo_step;
    assign acc_abs    = acc_q[WIDTH-1] ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op_next_d = op_next_q;
        arg_d     = arg_q;
        acc_d     = acc_q;
        disp_d    = disp_q;
        entered_d = entered_q;
        key_d     = key_q;
        err_d     = err_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;

        case (state_q)
            S_CLEAR: begin
                arg_d     = '0;
                acc_d     = '0;
                op_d      = OP_PLUS;
                op_next_d = OP_PLUS;
                entered_d = 1'b0;
                err_d     = 1'b0;
                disp_d    = '0;
                state_d   = S_IDLE;
            end

            S_IDLE: begin
                if (key_event) begin
                    count_d = count_q + 8'd1;
                    key_d   = bus.key_code;
                    if (bus.key_code <= 4'd9) begin
                        state_d = S_DIGIT;
                    end else begin
                        state_d = S_CALC;
                        case (bus.key_code)
                            4'hA:    op_next_d = OP_DIV;
                            4'hB:    op_next_d = OP_MUL;
                            4'hC:    state_d   = S_CLEAR;
                            4'hD:    op_next_d = OP_LOAD;
                            4'hE:    op_next_d = OP_PLUS;
                            default: op_next_d = OP_MINUS;
                        endcase
                    end
                end
            end

            S_DIGIT: begin
                if (arg_fits) begin
                    arg_d = arg_append[WIDTH-1:0];
                end
                entered_d = 1'b1;
                state_d   = S_SHOW_ARG;
            end

            S_SHOW_ARG: begin
                disp_d  = arg_q;
                state_d = S_IDLE;
            end

            S_CALC: begin
                if (op_q == OP_DIV) begin
                    if (arg_q == '0) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        rem_d   = '0;
                        quo_d   = acc_abs;
                        dvs_d   = arg_q;
                        qneg_d  = acc_q[WIDTH-1];
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_DIV;
                    end
                end else if (!calc_fits) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    acc_d     = calc_res[WIDTH-1:0];
                    op_d      = op_next_q;
                    arg_d     = '0;
                    entered_d = 1'b0;
                    state_d   = S_SHOW_RES;
                end
            end

            S_DIV: begin
                rem_d = quo_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    acc_d     = qneg_q ? -quo_signed : quo_signed;
                    op_d      = op_next_q;
                    arg_d     = '0;
                    entered_d = 1'b0;
                    state_d   = S_SHOW_RES;
                end
            end

            S_SHOW_RES: begin
                disp_d  = acc_q;
                state_d = S_IDLE;
            end

            S_ERROR: begin
                err_d = 1'b1;
                if (key_event && (bus.key_code == 4'hC)) begin
                    count_d = count_q + 8'd1;
                    state_d = S_CLEAR;
                end
            end

            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CLEAR;
            op_q       <= OP_PLUS;
            op_next_q  <= OP_PLUS;
            arg_q      <= '0;
            acc_q      <= '0;
            disp_q     <= '0;
            entered_q  <= 1'b0;
            prev_key_q <= 1'b0;
            key_q      <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op_next_q  <= op_next_d;
            arg_q      <= arg_d;
            acc_q      <= acc_d;
            disp_q     <= disp_d;
            entered_q  <= entered_d;
            prev_key_q <= bus.key_pressed;
            key_q      <= key_d;
            err_q      <= err_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
        end
    end

    // The most negative value has magnitude 2^(WIDTH-1), which still fits unsigned.
    logic [WIDTH-1:0] disp_abs;
    assign disp_abs = disp_q[WIDTH-1] ? -disp_q : disp_q;

    assign bus.disp_mag  = (state_q == S_ERROR) ? '0 : disp_abs;
    assign bus.disp_neg  = (state_q != S_ERROR) && disp_q[WIDTH-1];
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign bus.state_dbg = state_q;
    assign bus.key_count = count_q;
endmodule

// File: tb/tb_calc_core_param.sv
// Random key stream checked against an arithmetic calculator model, plus directed
// chain, sign, divide, error, digit-limit, held-key and mid-divide reset cases.
module tb_calc_core_param;
    localparam int WIDTH   = 16;
    localparam int MAX_ARG = 9999;
    localparam int K_DIV = 10, K_MUL = 11, K_CLR = 12, K_EQ = 13, K_ADD = 14, K_SUB = 15;
    localparam longint LO = -(64'sd1 <<< (WIDTH - 1));
    localparam longint HI = (64'sd1 <<< (WIDTH - 1)) - 1;

    logic Clk   = 1'b0;
    logic rst_n = 1'b0;

    calc_core_param_if #(.WIDTH(WIDTH)) bus ();

    calc_core_param #(.WIDTH(WIDTH), .MAX_ARG(MAX_ARG)) dut (
        .Clk   (Clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int chain_k [7] = '{1, 2, K_ADD, 3, K_SUB, 5, K_EQ};
    int chain_d [7] = '{1, 12, 12, 3, 15, 5, 10};

    // Behavioural model: operator held as the key code that chose it, K_EQ meaning load.
    longint m_arg, m_acc, m_disp;
    int     m_op;
    bit     m_entered, m_err;
    int     m_count;

    int cyc       = 0;
    int fall_cyc  = -1;
    bit busy_prev = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (busy_prev && bus.busy === 1'b0) fall_cyc <= cyc;
        busy_prev <= (bus.busy === 1'b1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_arg     = 0;
        m_acc     = 0;
        m_op      = K_ADD;
        m_entered = 1'b0;
        m_err     = 1'b0;
        m_disp    = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_count = 0;
    endfunction

    function automatic void model_key(input int code);
        longint r;
        bit     fail;
        if (m_err && code != K_CLR) return;
        m_count = (m_count + 1) % 256;
        if (code == K_CLR) begin
            model_clear();
            return;
        end
        if (code <= 9) begin
            if (m_arg * 10 + code <= MAX_ARG) m_arg = m_arg * 10 + code;
            m_entered = 1'b1;
            m_disp    = m_arg;
            return;
        end
        fail = 1'b0;
        r    = m_acc;
        case (m_op)
            K_ADD: r = m_acc + m_arg;
            K_SUB: r = m_acc - m_arg;
            K_MUL: r = m_acc * m_arg;
            K_DIV: if (m_arg == 0) fail = 1'b1; else r = m_acc / m_arg;
            default: r = m_entered ? m_arg : m_acc;
        endcase
        if (r < LO || r > HI) fail = 1'b1;
        if (fail) begin
            m_err = 1'b1;
        end else begin
            m_acc     = r;
            m_op      = code;
            m_arg     = 0;
            m_entered = 1'b0;
            m_disp    = r;
        end
    endfunction

    always @(negedge Clk) begin
        longint em;
        if (chk_en && rst_n && bus.busy === 1'b0) begin
            em = m_err ? 0 : ((m_disp < 0) ? -m_disp : m_disp);
            check("disp_mag", bus.disp_mag, em);
            check("disp_neg", bus.disp_neg, (!m_err && m_disp < 0) ? 1 : 0);
            check("err", bus.err, m_err ? 1 : 0);
            check("key_count", bus.key_count, m_count);
            check("state_dbg", bus.state_dbg, m_err ? 15 : 0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 300) check("idle_bound", bus.busy, 0);
    endtask

    // Press a key, hold it for 'hold' falling edges, optionally tap 'drop' while busy,
    // and report the edges from the key event until busy fell.
    task automatic press(input int code, input int hold, input int drop, output int lat);
        int t0;
        int n;
        wait_idle();
        @(negedge Clk);
        bus.key_code    = 4'(code);
        bus.key_pressed = 1'b1;
        @(posedge Clk);
        #1;
        t0 = cyc;
        model_key(code);
        repeat (hold) @(negedge Clk);
        bus.key_pressed = 1'b0;
        if (drop >= 0) begin
            repeat (2) @(negedge Clk);
            bus.key_code    = 4'(drop);
            bus.key_pressed = 1'b1;
            repeat (2) @(negedge Clk);
            bus.key_pressed = 1'b0;
        end
        n = 0;
        while (bus.busy !== 1'b0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        #1;
        check("busy_bound", bus.busy, 0);
        lat = (fall_cyc > t0) ? fall_cyc - t0 : 0;
    endtask

    task automatic tap(input int code);
        int lat;
        press(code, 1, -1, lat);
    endtask

    task automatic expect_disp(input string name, input int neg, input int mag);
        check({name, "_neg"}, bus.disp_neg, neg);
        check({name, "_mag"}, bus.disp_mag, mag);
    endtask

    task automatic do_reset();
        chk_en          = 1'b0;
        bus.key_pressed = 1'b0;
        bus.key_code    = 4'd0;
        rst_n           = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        check("rst_mag", bus.disp_mag, 0);
        check("rst_neg", bus.disp_neg, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_count", bus.key_count, 0);
        check("rst_state", bus.state_dbg, 8);
        rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_exit_state", bus.state_dbg, 0);
        chk_en = 1'b1;
    endtask

    initial begin
        int lat;
        int r;
        int c;
        bus.key_pressed = 1'b0;
        bus.key_code    = 4'd0;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            press(chain_k[i], 1, -1, lat);
            check("chain_disp", bus.disp_mag, chain_d[i]);
            check("chain_lat", lat, 2);
        end
        check("chain_count", bus.key_count, 7);
        check("chain_err", bus.err, 0);
        check("model_pin_chain", m_disp, 10);

        do_reset();
        tap(3); tap(K_SUB); tap(8); tap(K_MUL);
        expect_disp("negmul_mid", 1, 5);
        tap(4); tap(K_EQ);
        expect_disp("negmul_end", 1, 20);

        do_reset();
        tap(1); tap(0); tap(0); tap(K_DIV); tap(7);
        press(K_EQ, 1, 5, lat);
        check("div_lat", lat, WIDTH + 2);
        expect_disp("div", 0, 14);
        check("div_drop_count", bus.key_count, 6);
        tap(5); tap(K_DIV);
        press(K_EQ, 1, -1, lat);
        check("div0_lat", lat, 1);
        check("div0_err", bus.err, 1);
        expect_disp("div0", 0, 0);
        check("div0_state", bus.state_dbg, 15);
        press(K_CLR, 1, -1, lat);
        check("clr_lat", lat, 1);
        check("clr_err", bus.err, 0);
        expect_disp("clr", 0, 0);
        check("clr_count", bus.key_count, 10);

        for (int i = 0; i < 4; i++) tap(9);
        tap(K_MUL);
        for (int i = 0; i < 4; i++) tap(9);
        tap(K_EQ);
        check("ovf_err", bus.err, 1);
        check("ovf_count", bus.key_count, 20);
        press(7, 1, -1, lat);
        check("err_ignore_lat", lat, 0);
        check("err_ignore_count", bus.key_count, 20);
        check("err_ignore_err", bus.err, 1);
        expect_disp("err_ignore", 0, 0);
        tap(K_CLR);
        check("model_pin_clear", m_err, 0);

        tap(K_SUB); tap(4); tap(0); tap(9); tap(6); tap(K_MUL); tap(8); tap(K_EQ);
        expect_disp("min_neg", 1, 32768);
        tap(K_DIV); tap(1);
        press(K_EQ, 1, -1, lat);
        check("min_div_lat", lat, WIDTH + 2);
        expect_disp("min_div1", 1, 32768);
        tap(K_DIV); tap(3); tap(K_EQ);
        expect_disp("min_div3", 1, 10922);
        check("model_pin_trunc", m_disp, -10922);

        do_reset();
        tap(1); tap(2); tap(3); tap(4); tap(5);
        expect_disp("digit_limit", 0, 1234);
        check("digit_limit_count", bus.key_count, 5);
        press(6, 100, -1, lat);
        check("held_count", bus.key_count, 6);
        expect_disp("held", 0, 1234);

        do_reset();
        tap(1); tap(0); tap(0); tap(K_DIV); tap(7);
        wait_idle();
        @(negedge Clk);
        bus.key_code    = 4'(K_EQ);
        bus.key_pressed = 1'b1;
        @(posedge Clk);
        #1;
        repeat (4) @(negedge Clk);
        check("mid_div_state", bus.state_dbg, 9);
        bus.key_pressed = 1'b0;
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mag", bus.disp_mag, 0);
        check("mid_rst_neg", bus.disp_neg, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_busy", bus.busy, 1);
        check("mid_rst_count", bus.key_count, 0);
        check("mid_rst_state", bus.state_dbg, 8);
        model_reset();
        @(negedge Clk);
        rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("mid_rst_exit", bus.state_dbg, 0);
        chk_en = 1'b1;

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      c = $urandom_range(0, 9);
            else if (r < 62) c = K_CLR;
            else             c = $urandom_range(10, 15);
            press(c, $urandom_range(1, 3), -1, lat);
        end

        wait_idle();
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        bad++;
        $display("FAIL watchdog: time %0t reached, required finish before 5000000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
